// File: rtl/serial_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : serial_word_assembler
//  Purpose  : Collects a framed serial bit stream into n-bit words. Each
//             completed word is presented on R_out together with a one-cycle
//             Load strobe, intended to drive the R and L inputs of a
//             downstream load-enable register. A Start seen in the middle of a
//             frame aborts that frame, pulses Error and begins a new frame.
//  Ports    : Clock  - rising-edge clock
//             Reset  - asynchronous, active-high reset
//             Din    - serial data bit, sampled only when Valid=1
//             Valid  - Din qualifier; Valid=0 cycles are stalls
//             Start  - first bit of a frame (meaningful with Valid=1)
//             R_out  - last completed word (held between Loads)
//             Load   - one-cycle pulse when R_out updates
//             Busy   - high while a frame is partially received
//             Error  - one-cycle pulse on a Start seen mid-frame
//  Revision : 1.0 - initial release
// ============================================================================
module serial_word_assembler #(
    parameter int n         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Din,
    input  logic         Valid,
    input  logic         Start,
    output logic [n-1:0] R_out,
    output logic         Load,
    output logic         Busy,
    output logic         Error
);

    localparam int              c_CW   = (n > 2) ? $clog2(n) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(n - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t          r_state;
    logic [c_CW-1:0] r_count;
    logic [n-1:0]    r_shift;
    logic [n-1:0]    r_word;
    logic            r_load;
    logic            r_busy;
    logic            r_error;

    // w_shift_cont: shift register with Din appended to the running frame.
    // w_shift_new : shift register holding only Din as bit 0 of a new frame.
    logic [n-1:0]    w_shift_cont;
    logic [n-1:0]    w_shift_new;

    generate
        if (MSB_FIRST) begin : g_msb_first
            // Shift left, Din enters at the LSB; bit 0 ends up in [n-1].
            assign w_shift_cont = {r_shift[n-2:0], Din};
            assign w_shift_new  = {{(n-1){1'b0}}, Din};
        end else begin : g_lsb_first
            // Shift right, Din enters at the MSB; bit 0 ends up in [0].
            assign w_shift_cont = {Din, r_shift[n-1:1]};
            assign w_shift_new  = {Din, {(n-1){1'b0}}};
        end
    endgenerate

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_shift <= '0;
            r_word  <= '0;
            r_load  <= 1'b0;
            r_busy  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            // Strobes default low so they last exactly one cycle.
            r_load  <= 1'b0;
            r_error <= 1'b0;
            if (Valid) begin
                case (r_state)
                    ST_IDLE: begin
                        // Bits outside a frame are dropped until a Start.
                        if (Start) begin
                            r_shift <= w_shift_new;
                            r_count <= c_ONE;
                            r_state <= ST_SHIFT;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        if (Start) begin
                            // Abort: current Din restarts the frame as bit 0.
                            r_error <= 1'b1;
                            r_shift <= w_shift_new;
                            r_count <= c_ONE;
                        end else if (r_count == c_LAST) begin
                            r_word  <= w_shift_cont;
                            r_shift <= w_shift_cont;
                            r_load  <= 1'b1;
                            r_count <= '0;
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_shift <= w_shift_cont;
                            r_count <= r_count + c_ONE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_count <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign R_out = r_word;
    assign Load  = r_load;
    assign Busy  = r_busy;
    assign Error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_word_assembler
//  Purpose  : Directed self-checking bench for serial_word_assembler. Two
//             instances (MSB_FIRST=1 and MSB_FIRST=0) share one input stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_word_assembler;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Din   = 1'b0;
    logic       Valid = 1'b0;
    logic       Start = 1'b0;

    logic [7:0] m_rout, l_rout;
    logic       m_load, l_load, m_busy, l_busy, m_err, l_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_first  = 0;
    int t_second = 0;

    serial_word_assembler #(.n(8), .MSB_FIRST(1'b1)) dut_m (
        .Clock(Clock), .Reset(Reset), .Din(Din), .Valid(Valid), .Start(Start),
        .R_out(m_rout), .Load(m_load), .Busy(m_busy), .Error(m_err)
    );

    serial_word_assembler #(.n(8), .MSB_FIRST(1'b0)) dut_l (
        .Clock(Clock), .Reset(Reset), .Din(Din), .Valid(Valid), .Start(Start),
        .R_out(l_rout), .Load(l_load), .Busy(l_busy), .Error(l_err)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc++;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one input vector for one clock edge; returns 1 time unit after
    // the edge so the registered outputs reflect that edge.
    task automatic step(input logic d, input logic v, input logic s);
        @(negedge Clock);
        Din   = d;
        Valid = v;
        Start = s;
        @(posedge Clock);
        #1;
    endtask

    // Send a word first-bit = w[7], Start on the first bit, with up to
    // maxgap Valid=0 cycles before each later bit. Checks mid-frame status.
    task automatic send_word(input logic [7:0] w, input int maxgap, input string tag);
        for (int i = 7; i >= 0; i--) begin
            if (i < 7 && maxgap > 0) begin
                int g;
                g = $urandom_range(maxgap, 0);
                repeat (g) begin
                    step(1'b0, 1'b0, 1'b0);
                    chk({tag, "_gap_busy"}, 8'(m_busy), 8'h01);
                    chk({tag, "_gap_load"}, 8'(m_load), 8'h00);
                end
            end
            step(w[i], 1'b1, (i == 7));
            if (i > 0) begin
                chk({tag, "_mid_busy"}, 8'(m_busy), 8'h01);
                chk({tag, "_mid_load"}, 8'(m_load), 8'h00);
            end
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_rout_m", m_rout, 8'h00);
        chk("rst_rout_l", l_rout, 8'h00);
        chk("rst_load",   8'(m_load), 8'h00);
        chk("rst_busy",   8'(m_busy), 8'h00);
        chk("rst_err",    8'(m_err),  8'h00);
        @(negedge Clock);
        Reset = 1'b0;

        // Bits without Start are dropped while idle.
        step(1'b1, 1'b1, 1'b0);
        chk("idle_drop_busy", 8'(m_busy), 8'h00);

        // ---------------- test 1: 1,0,1,0,0,1,0,1 ----------------
        send_word(8'hA5, 0, "t1");
        chk("t1_load",   8'(m_load), 8'h01);
        chk("t1_rout_m", m_rout, 8'hA5);
        chk("t1_rout_l", l_rout, 8'hA5);
        chk("t1_busy",   8'(m_busy), 8'h00);
        chk("t1_err",    8'(m_err),  8'h00);
        step(1'b0, 1'b0, 1'b0);
        chk("t1_load_end", 8'(m_load), 8'h00);
        chk("t1_hold",     m_rout, 8'hA5);

        // ---------------- test 2: 1,1,0,0,0,0,0,0 ----------------
        send_word(8'hC0, 0, "t2");
        chk("t2_load_l", 8'(l_load), 8'h01);
        chk("t2_rout_m", m_rout, 8'hC0);
        chk("t2_rout_l", l_rout, 8'h03);

        // ---------------- test 3: 8'h3C with stalls ----------------
        send_word(8'h3C, 3, "t3");
        chk("t3_load",   8'(m_load), 8'h01);
        chk("t3_rout_m", m_rout, 8'h3C);
        chk("t3_rout_l", l_rout, 8'h3C);
        step(1'b0, 1'b0, 1'b0);
        chk("t3_single_load", 8'(m_load), 8'h00);

        // ---------------- test 4: restart after 4 bits ----------------
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("t4_pre_err", 8'(m_err), 8'h00);
        step(1'b1, 1'b1, 1'b1);
        chk("t4_err_m",  8'(m_err),  8'h01);
        chk("t4_err_l",  8'(l_err),  8'h01);
        chk("t4_noload", 8'(m_load), 8'h00);
        chk("t4_busy",   8'(m_busy), 8'h01);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (i == 0) chk("t4_err_end", 8'(m_err), 8'h00);
            if (i < 6)  chk("t4_mid_load", 8'(m_load), 8'h00);
        end
        chk("t4_load",   8'(m_load), 8'h01);
        chk("t4_rout_m", m_rout, 8'hFF);
        chk("t4_rout_l", l_rout, 8'hFF);

        // ---------------- test 5: reset mid-frame ----------------
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
        chk("t5_busy_pre", 8'(m_busy), 8'h01);
        #2;
        Reset = 1'b1;
        #1;
        chk("t5_rst_rout_m", m_rout, 8'h00);
        chk("t5_rst_rout_l", l_rout, 8'h00);
        chk("t5_rst_busy",   8'(m_busy), 8'h00);
        chk("t5_rst_load",   8'(m_load), 8'h00);
        chk("t5_rst_err",    8'(m_err),  8'h00);
        @(negedge Clock);
        Reset = 1'b0;
        send_word(8'h81, 0, "t5");
        chk("t5_load",   8'(m_load), 8'h01);
        chk("t5_rout_m", m_rout, 8'h81);
        chk("t5_rout_l", l_rout, 8'h81);

        // ---------------- test 6: back-to-back frames ----------------
        step(1'b0, 1'b0, 1'b0);
        send_word(8'h12, 0, "t6a");
        chk("t6a_load",   8'(m_load), 8'h01);
        chk("t6a_rout_m", m_rout, 8'h12);
        chk("t6a_rout_l", l_rout, 8'h48);
        t_first = cyc;
        send_word(8'h34, 0, "t6b");
        chk("t6b_load",   8'(m_load), 8'h01);
        chk("t6b_rout_m", m_rout, 8'h34);
        chk("t6b_rout_l", l_rout, 8'h2C);
        t_second = cyc;
        chk("t6_spacing", 8'(t_second - t_first), 8'd8);
        chk("t6_err",     8'(m_err), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
